// File: rtl/rgb_gray_pipe_pkg.sv
// -----------------------------------------------------------------------------
// rgb_gray_pkg
// Shared constants for the RGB-to-grayscale pipeline. It holds the per-pixel
// mode encodings, the default Q0.8 luminance weights and the Q0.8 rounding
// constant that is added before the >>8.
// There are no ports. The package is imported by rgb_gray_mac and rgb_gray_pipe.
// -----------------------------------------------------------------------------
package rgb_gray_pkg;

  // Per-pixel output mode.
  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_GRAY = 2'd1;
  localparam logic [1:0] MODE_INV  = 2'd2;
  localparam logic [1:0] MODE_BIN  = 2'd3;

  // Default luminance weights in Q0.8 (0.30 / 0.59 / 0.11).
  localparam int unsigned DEF_WR = 77;
  localparam int unsigned DEF_WG = 150;
  localparam int unsigned DEF_WB = 29;

  // Half an LSB in Q0.8. Adding it before the >>8 rounds to nearest.
  localparam int unsigned ROUND_Q8 = 128;

endpackage

// File: rtl/rgb_gray_pipe_if.sv
// -----------------------------------------------------------------------------
// rgb_gray_pipe_if
// Pixel bus of the grayscale stage. The input side carries the upstream pixel
// together with its mode and threshold. The output side carries the processed
// pixel and, in the frame-minimum build, the frame-minimum report.
// Optional feature macro: RGB_GRAY_FRAME_MIN_EN adds iFRAME_START, oFRAME_MIN
// and oMIN_VALID.
// Modports:
//   master : the pixel producer/consumer. It drives the i* signals and reads the o* signals.
//   slave  : rgb_gray_pipe. It reads the i* signals and drives the o* signals.
// -----------------------------------------------------------------------------
interface rgb_gray_pipe_if #(
  parameter int unsigned DW = 10
);
  logic          iDVAL;
  logic [DW-1:0] iRed;
  logic [DW-1:0] iGreen;
  logic [DW-1:0] iBlue;
  logic [1:0]    iMODE;
  logic [DW-1:0] iTHRESH;
`ifdef RGB_GRAY_FRAME_MIN_EN
  logic          iFRAME_START;
  logic [DW-1:0] oFRAME_MIN;
  logic          oMIN_VALID;
`endif
  logic          oDVAL;
  logic [DW-1:0] oDATA_R;
  logic [DW-1:0] oDATA_G;
  logic [DW-1:0] oDATA_B;

  modport master (
    output iDVAL, iRed, iGreen, iBlue, iMODE, iTHRESH,
`ifdef RGB_GRAY_FRAME_MIN_EN
    output iFRAME_START,
    input  oFRAME_MIN, oMIN_VALID,
`endif
    input  oDVAL, oDATA_R, oDATA_G, oDATA_B
  );

  modport slave (
    input  iDVAL, iRed, iGreen, iBlue, iMODE, iTHRESH,
`ifdef RGB_GRAY_FRAME_MIN_EN
    input  iFRAME_START,
    output oFRAME_MIN, oMIN_VALID,
`endif
    output oDVAL, oDATA_R, oDATA_G, oDATA_B
  );

endinterface

// File: rtl/rgb_gray_pipe_mac.sv
// -----------------------------------------------------------------------------
// rgb_gray_mac
// This block holds the first two stages of the grayscale pipeline.
//   S1 registers R*WR, G*WG and B*WB, each DW+8 bits wide, and the raw R/G/B.
//   S2 registers the sum of the products plus ROUND_Q8 in DW+10 bits. That
//   width holds three full-scale products plus the rounding constant, so the
//   sum cannot overflow.
// The block does not handle the valid bit or any other sideband signals. The top level
// delays those alongside this datapath.
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous reset, active-low
//   r_p0/g_p0/b_p0 input components (DW)
//   sum_p2        rounded weighted sum, not yet shifted (DW+10)
//   r_p2/g_p2/b_p2 raw components delayed to line up with sum_p2
// -----------------------------------------------------------------------------
module rgb_gray_mac
  import rgb_gray_pkg::*;
#(
  parameter int unsigned DW = 10,
  parameter int unsigned WR = DEF_WR,
  parameter int unsigned WG = DEF_WG,
  parameter int unsigned WB = DEF_WB
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [DW-1:0]  r_p0,
  input  logic [DW-1:0]  g_p0,
  input  logic [DW-1:0]  b_p0,
  output logic [DW+9:0]  sum_p2,
  output logic [DW-1:0]  r_p2,
  output logic [DW-1:0]  g_p2,
  output logic [DW-1:0]  b_p2
);

  localparam logic [7:0]    WR_Q8 = 8'(WR);
  localparam logic [7:0]    WG_Q8 = 8'(WG);
  localparam logic [7:0]    WB_Q8 = 8'(WB);
  localparam logic [DW+9:0] RND   = (DW+10)'(ROUND_Q8);

  logic [DW+7:0] prod_r_p1_d, prod_r_p1_q;
  logic [DW+7:0] prod_g_p1_d, prod_g_p1_q;
  logic [DW+7:0] prod_b_p1_d, prod_b_p1_q;
  logic [DW-1:0] r_p1_d, r_p1_q, g_p1_d, g_p1_q, b_p1_d, b_p1_q;
  logic [DW+9:0] sum_p2_d, sum_p2_q;
  logic [DW-1:0] r_p2_d, r_p2_q, g_p2_d, g_p2_q, b_p2_d, b_p2_q;

  always_comb begin
    // ---- S0 -> S1: weighted products, raw components ----
    prod_r_p1_d = {8'd0, r_p0} * {{DW{1'b0}}, WR_Q8};
    prod_g_p1_d = {8'd0, g_p0} * {{DW{1'b0}}, WG_Q8};
    prod_b_p1_d = {8'd0, b_p0} * {{DW{1'b0}}, WB_Q8};
    r_p1_d      = r_p0;
    g_p1_d      = g_p0;
    b_p1_d      = b_p0;
    // ---- S1 -> S2: sum plus rounding constant ----
    sum_p2_d    = {2'd0, prod_r_p1_q} + {2'd0, prod_g_p1_q}
                + {2'd0, prod_b_p1_q} + RND;
    r_p2_d      = r_p1_q;
    g_p2_d      = g_p1_q;
    b_p2_d      = b_p1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_r_p1_q <= '0;
      prod_g_p1_q <= '0;
      prod_b_p1_q <= '0;
      r_p1_q      <= '0;
      g_p1_q      <= '0;
      b_p1_q      <= '0;
      sum_p2_q    <= '0;
      r_p2_q      <= '0;
      g_p2_q      <= '0;
      b_p2_q      <= '0;
    end else begin
      prod_r_p1_q <= prod_r_p1_d;
      prod_g_p1_q <= prod_g_p1_d;
      prod_b_p1_q <= prod_b_p1_d;
      r_p1_q      <= r_p1_d;
      g_p1_q      <= g_p1_d;
      b_p1_q      <= b_p1_d;
      sum_p2_q    <= sum_p2_d;
      r_p2_q      <= r_p2_d;
      g_p2_q      <= g_p2_d;
      b_p2_q      <= b_p2_d;
    end
  end

  assign sum_p2 = sum_p2_q;
  assign r_p2   = r_p2_q;
  assign g_p2   = g_p2_q;
  assign b_p2   = b_p2_q;

endmodule

// File: rtl/rgb_gray_pipe.sv
// -----------------------------------------------------------------------------
// rgb_gray_pipe
// RGB-to-grayscale stage that sits between the Bayer-to-RGB converter and the
// pupil search. It computes rounded, saturated, weighted luminance with a fixed
// latency of 3 cycles and has no stall input. rgb_gray_mac forms the products and
// the rounded sum (S1, S2). This level does the shift, the saturation and the
// per-pixel mode select (S3). It also keeps the optional frame-minimum tracker.
// Optional feature macro: RGB_GRAY_FRAME_MIN_EN enables the frame-minimum
// tracker and its ports.
// Ports:
//   iCLK  rising-edge pixel clock
//   iRST  synchronous reset, active-low
//   bus   rgb_gray_pipe_if.slave with these signals:
//         iDVAL, iRed/iGreen/iBlue, iMODE, iTHRESH, [iFRAME_START] are inputs.
//         oDVAL, oDATA_R/G/B, [oFRAME_MIN, oMIN_VALID] are outputs.
// -----------------------------------------------------------------------------
module rgb_gray_pipe
  import rgb_gray_pkg::*;
#(
  parameter int unsigned DW = 10,
  parameter int unsigned WR = DEF_WR,
  parameter int unsigned WG = DEF_WG,
  parameter int unsigned WB = DEF_WB
) (
  input  logic           iCLK,
  input  logic           iRST,
  rgb_gray_pipe_if.slave bus
);

  localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};

  // Drop the 8 fractional bits. If anything remains above DW bits, the
  // weights sum to more than 1.0, so the result is clamped instead of wrapping.
  function automatic logic [DW-1:0] round_sat(input logic [DW+9:0] sum);
    logic [DW+9:0]  shifted;
    logic [DW-1:0]  res;
    shifted = sum >> 8;
    if (|shifted[DW+9:DW]) res = ALL_ONES;
    else                   res = shifted[DW-1:0];
    return res;
  endfunction

  logic          vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
  logic [1:0]    mode_p1_d, mode_p1_q, mode_p2_d, mode_p2_q;
  logic [DW-1:0] thr_p1_d, thr_p1_q, thr_p2_d, thr_p2_q;
  logic [DW+9:0] sum_p2;
  logic [DW-1:0] r_p2, g_p2, b_p2;
  logic [DW-1:0] y_p2;
  logic          dval_p3_d, dval_p3_q;
  logic [DW-1:0] dr_p3_d, dr_p3_q, dg_p3_d, dg_p3_q, db_p3_d, db_p3_q;

  rgb_gray_mac #(
    .DW (DW),
    .WR (WR),
    .WG (WG),
    .WB (WB)
  ) u_mac (
    .clk    (iCLK),
    .rst_n  (iRST),
    .r_p0   (bus.iRed),
    .g_p0   (bus.iGreen),
    .b_p0   (bus.iBlue),
    .sum_p2 (sum_p2),
    .r_p2   (r_p2),
    .g_p2   (g_p2),
    .b_p2   (b_p2)
  );

  always_comb begin
    // ---- S0 -> S1: sideband sampled with the pixel ----
    vld_p1_d  = bus.iDVAL;
    mode_p1_d = bus.iMODE;
    thr_p1_d  = bus.iTHRESH;
    // ---- S1 -> S2 ----
    vld_p2_d  = vld_p1_q;
    mode_p2_d = mode_p1_q;
    thr_p2_d  = thr_p1_q;
    // ---- S2 -> S3: saturate, then apply the pixel's own mode ----
    y_p2      = round_sat(sum_p2);
    dval_p3_d = vld_p2_q;
    dr_p3_d   = r_p2;
    dg_p3_d   = g_p2;
    db_p3_d   = b_p2;
    case (mode_p2_q)
      MODE_GRAY: begin
        dr_p3_d = y_p2;
        dg_p3_d = y_p2;
        db_p3_d = y_p2;
      end
      MODE_INV: begin
        dr_p3_d = ALL_ONES - y_p2;
        dg_p3_d = ALL_ONES - y_p2;
        db_p3_d = ALL_ONES - y_p2;
      end
      MODE_BIN: begin
        // Pixels strictly darker than the threshold are marked as pupil candidates (all-ones).
        dr_p3_d = (y_p2 < thr_p2_q) ? ALL_ONES : '0;
        dg_p3_d = dr_p3_d;
        db_p3_d = dr_p3_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      mode_p1_q <= '0;
      mode_p2_q <= '0;
      thr_p1_q  <= '0;
      thr_p2_q  <= '0;
      dval_p3_q <= 1'b0;
      dr_p3_q   <= '0;
      dg_p3_q   <= '0;
      db_p3_q   <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      mode_p1_q <= mode_p1_d;
      mode_p2_q <= mode_p2_d;
      thr_p1_q  <= thr_p1_d;
      thr_p2_q  <= thr_p2_d;
      dval_p3_q <= dval_p3_d;
      dr_p3_q   <= dr_p3_d;
      dg_p3_q   <= dg_p3_d;
      db_p3_q   <= db_p3_d;
    end
  end

  assign bus.oDVAL   = dval_p3_q;
  assign bus.oDATA_R = dr_p3_q;
  assign bus.oDATA_G = dg_p3_q;
  assign bus.oDATA_B = db_p3_q;

`ifdef RGB_GRAY_FRAME_MIN_EN
  logic          fs_p1_d, fs_p1_q, fs_p2_d, fs_p2_q;
  logic [DW-1:0] run_min_d, run_min_q;
  logic [DW-1:0] frame_min_d, frame_min_q;
  logic          min_vld_d, min_vld_q;

  always_comb begin
    // ---- S0 -> S1 / S1 -> S2: frame start travels with its pixel ----
    fs_p1_d     = bus.iFRAME_START & bus.iDVAL;
    fs_p2_d     = fs_p1_q;
    // ---- S2 -> S3: running minimum over every valid pixel, any mode ----
    run_min_d   = run_min_q;
    frame_min_d = frame_min_q;
    min_vld_d   = 1'b0;
    if (vld_p2_q) begin
      if (fs_p2_q) begin
        // The start pixel closes the previous frame and also seeds the new one.
        frame_min_d = run_min_q;
        min_vld_d   = 1'b1;
        run_min_d   = y_p2;
      end else if (y_p2 < run_min_q) begin
        run_min_d   = y_p2;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      fs_p1_q     <= 1'b0;
      fs_p2_q     <= 1'b0;
      run_min_q   <= ALL_ONES;
      frame_min_q <= ALL_ONES;
      min_vld_q   <= 1'b0;
    end else begin
      fs_p1_q     <= fs_p1_d;
      fs_p2_q     <= fs_p2_d;
      run_min_q   <= run_min_d;
      frame_min_q <= frame_min_d;
      min_vld_q   <= min_vld_d;
    end
  end

  assign bus.oFRAME_MIN = frame_min_q;
  assign bus.oMIN_VALID = min_vld_q;
`endif

endmodule

// File: tb/tb_rgb_gray_pipe.sv
// -----------------------------------------------------------------------------
// tb_rgb_gray_pipe
// Bench for rgb_gray_pipe. It runs two instances on the same input stream. One
// instance uses the default weights. The other uses WR=WG=WB=255 so that the
// saturation path is exercised. Expected outputs come from a fixed vector table,
// from hand-written sequences, and from an arithmetic reference model. That
// model applies the luminance formula directly and delays its results three
// cycles through a queue.
// Optional feature macro: RGB_GRAY_FRAME_MIN_EN adds the frame-minimum checks.
// -----------------------------------------------------------------------------
module tb_rgb_gray_pipe;
  import rgb_gray_pkg::*;

  localparam int DW   = 10;
  localparam int MAXV = 1023;

  typedef struct {
    logic vld;
    int   r, g, b;
    int   mode;
    int   thr;
    logic fs;
  } in_t;

  typedef struct {
    logic vld;
    int   r, g, b;
    int   sr, sg, sb;
    int   fmin;
    logic mvld;
  } exp_t;

  typedef struct {
    int r, g, b, mode, thr;
    int er, eg, eb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   m_run_min, m_frame_min;
  exp_t q[$];
  vec_t tbl[16];

  always #5 clk = ~clk;

  rgb_gray_pipe_if #(.DW(DW)) bus ();
  rgb_gray_pipe_if #(.DW(DW)) bus_s ();

  assign bus_s.iDVAL   = bus.iDVAL;
  assign bus_s.iRed    = bus.iRed;
  assign bus_s.iGreen  = bus.iGreen;
  assign bus_s.iBlue   = bus.iBlue;
  assign bus_s.iMODE   = bus.iMODE;
  assign bus_s.iTHRESH = bus.iTHRESH;
`ifdef RGB_GRAY_FRAME_MIN_EN
  assign bus_s.iFRAME_START = bus.iFRAME_START;
`endif

  rgb_gray_pipe #(.DW(DW)) dut (
    .iCLK (clk),
    .iRST (rst_n),
    .bus  (bus)
  );

  rgb_gray_pipe #(.DW(DW), .WR(255), .WG(255), .WB(255)) dut_s (
    .iCLK (clk),
    .iRST (rst_n),
    .bus  (bus_s)
  );

  // ---------------- reference model ----------------
  function automatic int gray(int r, int g, int b, int wr, int wg, int wb);
    int y;
    y = (r * wr + g * wg + b * wb + 128) / 256;
    if (y > MAXV) y = MAXV;
    return y;
  endfunction

  function automatic int map_out(int mode, int raw, int y, int thr);
    case (mode)
      0:       return raw;
      1:       return y;
      2:       return MAXV - y;
      default: return (y < thr) ? MAXV : 0;
    endcase
  endfunction

  function automatic exp_t model(in_t p);
    exp_t e;
    int   y, ys;
    y     = gray(p.r, p.g, p.b, 77, 150, 29);
    ys    = gray(p.r, p.g, p.b, 255, 255, 255);
    e.vld = p.vld;
    e.r   = map_out(p.mode, p.r, y, p.thr);
    e.g   = map_out(p.mode, p.g, y, p.thr);
    e.b   = map_out(p.mode, p.b, y, p.thr);
    e.sr  = map_out(p.mode, p.r, ys, p.thr);
    e.sg  = map_out(p.mode, p.g, ys, p.thr);
    e.sb  = map_out(p.mode, p.b, ys, p.thr);
    e.mvld = 1'b0;
    if (p.vld) begin
      if (p.fs) begin
        m_frame_min = m_run_min;
        e.mvld      = 1'b1;
        m_run_min   = y;
      end else if (y < m_run_min) begin
        m_run_min = y;
      end
    end
    e.fmin = m_frame_min;
    return e;
  endfunction

  function automatic in_t mk_in(logic vld, int r, int g, int b, int mode, int thr, logic fs);
    in_t p;
    p.vld = vld; p.r = r; p.g = g; p.b = b; p.mode = mode; p.thr = thr; p.fs = fs;
    return p;
  endfunction

  function automatic vec_t mkv(int r, int g, int b, int mode, int thr, int er, int eg, int eb);
    vec_t v;
    v.r = r; v.g = g; v.b = b; v.mode = mode; v.thr = thr;
    v.er = er; v.eg = eg; v.eb = eb;
    return v;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic drive(input in_t p);
    bus.iDVAL   = p.vld;
    bus.iRed    = 10'(p.r);
    bus.iGreen  = 10'(p.g);
    bus.iBlue   = 10'(p.b);
    bus.iMODE   = 2'(p.mode);
    bus.iTHRESH = 10'(p.thr);
`ifdef RGB_GRAY_FRAME_MIN_EN
    bus.iFRAME_START = p.fs;
`endif
  endtask

  // Drive one cycle and compare the output against the record that was pushed three cycles earlier.
  task automatic cycle(input in_t p, input exp_t e);
    exp_t x;
    @(posedge clk); #1;
    drive(p);
    q.push_back(e);
    @(negedge clk);
    if (q.size() > 3) begin
      x = q.pop_front();
      chk("dval", int'(bus.oDVAL), int'(x.vld));
      chk("dval_sat", int'(bus_s.oDVAL), int'(x.vld));
      if (x.vld) begin
        chk("data_r", int'(bus.oDATA_R), x.r);
        chk("data_g", int'(bus.oDATA_G), x.g);
        chk("data_b", int'(bus.oDATA_B), x.b);
        chk("sat_r", int'(bus_s.oDATA_R), x.sr);
        chk("sat_g", int'(bus_s.oDATA_G), x.sg);
        chk("sat_b", int'(bus_s.oDATA_B), x.sb);
      end
`ifdef RGB_GRAY_FRAME_MIN_EN
      chk("frame_min", int'(bus.oFRAME_MIN), x.fmin);
      chk("min_valid", int'(bus.oMIN_VALID), int'(x.mvld));
`endif
    end
  endtask

  task automatic idle_cycles(input int n);
    in_t p;
    for (int i = 0; i < n; i++) begin
      p = mk_in(1'b0, 0, 0, 0, 0, 0, 1'b0);
      cycle(p, model(p));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    in_t  p;
    exp_t e;
    int   fs_y[6];
    int   fs_m[6];
    logic fs_v[6];
    logic fs_s[6];
    int   fs_fmin[6];
    logic fs_mv[6];

    rst_n = 1'b0;
    drive(mk_in(1'b0, 0, 0, 0, 0, 0, 1'b0));

    tbl[0]  = mkv(5,    6,    7,    MODE_PASS, 0,   5,    6,    7);
    tbl[1]  = mkv(1023, 1023, 1023, MODE_GRAY, 0,   1023, 1023, 1023);
    tbl[2]  = mkv(1023, 0,    0,    MODE_INV,  0,   715,  715,  715);
    tbl[3]  = mkv(0,    0,    0,    MODE_BIN,  200, 1023, 1023, 1023);
    tbl[4]  = mkv(1023, 0,    0,    MODE_PASS, 0,   1023, 0,    0);
    tbl[5]  = mkv(1023, 0,    0,    MODE_GRAY, 0,   308,  308,  308);
    tbl[6]  = mkv(1023, 1023, 1023, MODE_INV,  0,   0,    0,    0);
    tbl[7]  = mkv(1023, 0,    0,    MODE_BIN,  200, 0,    0,    0);
    tbl[8]  = mkv(0,    1023, 0,    MODE_PASS, 0,   0,    1023, 0);
    tbl[9]  = mkv(0,    1023, 0,    MODE_GRAY, 0,   599,  599,  599);
    tbl[10] = mkv(0,    0,    1023, MODE_INV,  0,   907,  907,  907);
    tbl[11] = mkv(200,  200,  200,  MODE_BIN,  200, 0,    0,    0);
    tbl[12] = mkv(199,  199,  199,  MODE_BIN,  200, 1023, 1023, 1023);
    tbl[13] = mkv(200,  200,  200,  MODE_BIN,  201, 1023, 1023, 1023);
    tbl[14] = mkv(0,    0,    1023, MODE_GRAY, 0,   116,  116,  116);
    tbl[15] = mkv(100,  50,   25,   MODE_GRAY, 0,   62,   62,   62);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dval", int'(bus.oDVAL), 0);
    chk("rst_data_r", int'(bus.oDATA_R), 0);
    chk("rst_data_g", int'(bus.oDATA_G), 0);
    chk("rst_data_b", int'(bus.oDATA_B), 0);
    chk("rst_dval_sat", int'(bus_s.oDVAL), 0);
`ifdef RGB_GRAY_FRAME_MIN_EN
    chk("rst_frame_min", int'(bus.oFRAME_MIN), MAXV);
    chk("rst_min_valid", int'(bus.oMIN_VALID), 0);
`endif
    @(posedge clk); #1;
    rst_n       = 1'b1;
    m_run_min   = MAXV;
    m_frame_min = MAXV;

    // Table vectors back to back. The modes rotate from cycle to cycle.
    for (int i = 0; i < 16; i++) begin
      p    = mk_in(1'b1, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].mode, tbl[i].thr, 1'b0);
      e    = model(p);
      e.r  = tbl[i].er;
      e.g  = tbl[i].eg;
      e.b  = tbl[i].eb;
      cycle(p, e);
    end
    // Isolated pixel. The idle records around it check that oDVAL is high exactly 3 cycles later.
    idle_cycles(2);
    p = mk_in(1'b1, 1023, 1023, 1023, 1, 0, 1'b0);
    e = model(p);
    e.r = 1023; e.g = 1023; e.b = 1023; e.sr = 1023; e.sg = 1023; e.sb = 1023;
    cycle(p, e);
    idle_cycles(4);

    // Randomized stream checked against the model
    for (int i = 0; i < 400; i++) begin
      p.vld  = ($urandom_range(0, 3) != 0);
      p.r    = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 1023));
      p.g    = ($urandom_range(0, 7) == 0) ? 0    : int'($urandom_range(0, 1023));
      p.b    = int'($urandom_range(0, 1023));
      p.mode = int'($urandom_range(0, 3));
      p.thr  = int'($urandom_range(0, 1023));
      p.fs   = ($urandom_range(0, 15) == 0);
      cycle(p, model(p));
    end
    idle_cycles(3);

    // Two pixels are in flight when reset is pulsed for one cycle. Neither pixel may emerge.
    q.delete();
    @(posedge clk); #1;
    drive(mk_in(1'b1, 300, 300, 300, 1, 0, 1'b0));
    @(posedge clk); #1;
    drive(mk_in(1'b1, 400, 400, 400, 1, 0, 1'b0));
    @(posedge clk); #1;
    drive(mk_in(1'b0, 0, 0, 0, 0, 0, 1'b0));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_dval", int'(bus.oDVAL), 0);
      chk("flush_dval_sat", int'(bus_s.oDVAL), 0);
    end
`ifdef RGB_GRAY_FRAME_MIN_EN
    chk("flush_frame_min", int'(bus.oFRAME_MIN), MAXV);
`endif
    m_run_min   = MAXV;
    m_frame_min = MAXV;

    // Frame-minimum sequence: frame A is {500,120,300}, then a start at 900, then a start at 50.
    fs_y = '{500, 120, 300, 900, 0, 50};
    fs_m = '{3, 0, 2, 1, 0, 1};
    fs_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    fs_s = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    fs_fmin = '{1023, 1023, 1023, 120, 120, 900};
    fs_mv   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      p = mk_in(fs_v[i], fs_y[i], fs_y[i], fs_y[i], fs_m[i], 600, fs_s[i]);
      e = model(p);
`ifdef RGB_GRAY_FRAME_MIN_EN
      e.fmin = fs_fmin[i];
      e.mvld = fs_mv[i];
`endif
      cycle(p, e);
    end
    idle_cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
